// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded instruction bundle from ID and presents it to EX one cycle later.
// Handles flush (squash), hold (freeze), and, when ID_EX_LOAD_USE_STALL_EN is defined,
// detects load-use hazards, inserts a single bubble and counts bubbles (saturating).
// With the macro undefined, no hazard is ever detected and bubble_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   ctrl_i[14:0]              decoder bundle (MemRead is bit 3)
//   valid_i                   ID holds a real instruction
//   pc4_i, rs_data_i,
//   rt_data_i, imm_i          32-bit datapath values
//   rs_i, rt_i, rd_i, funct_i register indices and function field
//   flush_i                   squash the ID instruction (highest priority after reset)
//   hold_i                    freeze the ID/EX register
//   *_o (same names)          registered ID/EX copies
//   stall_o                   combinational: freeze PC and IF/ID this cycle
//   bubble_cnt_o              saturating count of inserted load-use bubbles
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [14:0] ctrl_i,
  input  logic        valid_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic [14:0] ctrl_o,
  output logic        valid_o,
  output logic [31:0] pc4_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic        stall_o,
  output logic [15:0] bubble_cnt_o
);

  logic [14:0] ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [5:0]  funct_q, funct_d;
  logic        hz;

`ifdef ID_EX_LOAD_USE_STALL_EN
  // A load in EX whose destination is read by the instruction in ID.
  assign hz = valid_q & ctrl_q[3] & valid_i & (rt_q != 5'd0) &
              ((rt_q == rs_i) | (rt_q == rt_i));
`else
  assign hz = 1'b0;
`endif

  assign stall_o = hz | hold_i;

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    funct_d   = funct_q;
    if (flush_i || (!hold_i && hz)) begin
      // Squash or bubble: everything cleared.
      ctrl_d    = '0;
      valid_d   = 1'b0;
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      funct_d   = '0;
    end else if (!hold_i) begin
      // An invalid slot never carries live control bits downstream.
      ctrl_d    = valid_i ? ctrl_i : '0;
      valid_d   = valid_i;
      pc4_d     = pc4_i;
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      rs_d      = rs_i;
      rt_d      = rt_i;
      rd_d      = rd_i;
      funct_d   = funct_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      funct_q   <= funct_d;
    end
  end

`ifdef ID_EX_LOAD_USE_STALL_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!flush_i && !hold_i && hz && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif

  assign ctrl_o    = ctrl_q;
  assign valid_o   = valid_q;
  assign pc4_o     = pc4_q;
  assign rs_data_o = rs_data_q;
  assign rt_data_o = rt_data_q;
  assign imm_o     = imm_q;
  assign rs_o      = rs_q;
  assign rt_o      = rt_q;
  assign rd_o      = rd_q;
  assign funct_o   = funct_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, scoreboard-checked bench for id_ex_stage. Hazard-specific expectations follow
// whether ID_EX_LOAD_USE_STALL_EN is defined for the build.
module tb_id_ex_stage;

  typedef struct packed {
    logic [14:0] ctrl;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } id_t;

  typedef struct packed {
    id_t         o;
    logic [15:0] cnt;
  } exp_t;

  // lw: RegWrite, ALUSrc, MemRead, MemToReg=01
  localparam logic [14:0] LwCtrl  = 15'h4409;
  // add: RegWrite, RegDst=01
  localparam logic [14:0] AddCtrl = 15'h4100;
  // jal: RegWrite, RegDst=10, Jump, MemToReg=11
  localparam logic [14:0] JalCtrl = 15'h4213;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i, hold_i;
  logic [14:0] ctrl_i, ctrl_o;
  logic [31:0] pc4_i, rs_data_i, rt_data_i, imm_i;
  logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_i, rt_i, rd_i, rs_o, rt_o, rd_o;
  logic [5:0]  funct_i, funct_o;
  logic        valid_o, stall_o;
  logic [15:0] bubble_cnt_o;

  id_ex_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ctrl_i      (ctrl_i),
    .valid_i     (valid_i),
    .pc4_i       (pc4_i),
    .rs_data_i   (rs_data_i),
    .rt_data_i   (rt_data_i),
    .imm_i       (imm_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .rd_i        (rd_i),
    .funct_i     (funct_i),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .ctrl_o      (ctrl_o),
    .valid_o     (valid_o),
    .pc4_o       (pc4_o),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .imm_o       (imm_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .rd_o        (rd_o),
    .funct_o     (funct_o),
    .stall_o     (stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   errors = 0;
  int   checks = 0;
  int   cnt_exp = 0;
  exp_t sb[$];
  id_t  last_o;
  id_t  zero_o = '0;

  function automatic id_t mk(input logic [14:0] c, input logic v, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input int seed);
    id_t r;
    r.ctrl  = c;
    r.valid = v;
    r.pc4   = 32'(seed) * 4;
    r.rsd   = 32'hA000_0000 + 32'(seed);
    r.rtd   = 32'hB000_0000 + 32'(seed);
    r.imm   = 32'hFFFF_0000 | 32'(seed);
    r.rs    = rs;
    r.rt    = rt;
    r.rd    = rd;
    r.funct = 6'(seed);
    return r;
  endfunction

  // Expected register contents after a normal load.
  function automatic id_t ld(input id_t i);
    id_t r = i;
    if (!i.valid) r.ctrl = '0;
    return r;
  endfunction

  task automatic drive(input id_t in, input logic f, input logic h, input logic r);
    {ctrl_i, valid_i, pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, funct_i} = in;
    flush_i = f;
    hold_i  = h;
    rst_i   = r;
  endtask

  task automatic expect_o(input id_t o);
    exp_t e;
    e.o   = o;
    e.cnt = (cnt_exp > 65535) ? 16'hFFFF : 16'(cnt_exp);
    sb.push_back(e);
    last_o = o;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    id_t  obs;
    @(posedge clk_i);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e   = sb.pop_front();
      obs = {ctrl_o, valid_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o, funct_o};
      assert (obs === e.o) else begin
        errors++;
        $error("FAIL %s: regs got %h want %h", tag, obs, e.o);
      end
      checks++;
      assert (bubble_cnt_o === e.cnt) else begin
        errors++;
        $error("FAIL %s_cnt: got %h want %h", tag, bubble_cnt_o, e.cnt);
      end
    end
  endtask

  task automatic chk_stall(input logic exp, input string tag);
    #1;
    checks++;
    assert (stall_o === exp) else begin
      errors++;
      $error("FAIL %s: stall_o got %b want %b", tag, stall_o, exp);
    end
  endtask

  logic hz_en;

  initial begin
    id_t a, b, lw, add, lw0, r0, x, c, j;
`ifdef ID_EX_LOAD_USE_STALL_EN
    hz_en = 1'b1;
`else
    hz_en = 1'b0;
`endif
    a   = mk(15'h7ff7, 1'b1, 5'd1, 5'd2, 5'd3, 11);
    b   = mk(15'h5a5a, 1'b0, 5'd5, 5'd5, 5'd4, 12);
    lw  = mk(LwCtrl, 1'b1, 5'd2, 5'd5, 5'd0, 13);
    add = mk(AddCtrl, 1'b1, 5'd5, 5'd6, 5'd7, 14);
    lw0 = mk(LwCtrl, 1'b1, 5'd3, 5'd0, 5'd0, 15);
    r0  = mk(AddCtrl, 1'b1, 5'd0, 5'd0, 5'd8, 16);
    x   = mk(15'h2a51, 1'b1, 5'd9, 5'd10, 5'd11, 17);
    c   = mk(15'h1402, 1'b1, 5'd12, 5'd13, 5'd14, 18);
    j   = mk(JalCtrl, 1'b1, 5'd0, 5'd0, 5'd31, 19);

    // Reset with garbage on the inputs.
    drive(a, 1'b0, 1'b0, 1'b1);
    expect_o(zero_o);
    tick("reset");
    chk_stall(1'b0, "stall_in_reset");
    expect_o(zero_o);
    tick("reset2");

    // Normal loads, valid and invalid.
    drive(a, 1'b0, 1'b0, 1'b0);
    chk_stall(1'b0, "stall_idle");
    expect_o(ld(a));
    tick("load_a");
    drive(b, 1'b0, 1'b0, 1'b0);
    expect_o(ld(b));
    tick("load_invalid");

    // lw $5 then add reading $5.
    drive(lw, 1'b0, 1'b0, 1'b0);
    expect_o(ld(lw));
    tick("load_lw");
    drive(add, 1'b0, 1'b0, 1'b0);
    chk_stall(hz_en, "stall_load_use");
    if (hz_en) begin
      cnt_exp++;
      expect_o(zero_o);
      tick("bubble");
      chk_stall(1'b0, "stall_released");
    end
    expect_o(ld(add));
    tick("add_enters");

    // Load to $0 never stalls.
    drive(lw0, 1'b0, 1'b0, 1'b0);
    expect_o(ld(lw0));
    tick("load_lw0");
    drive(r0, 1'b0, 1'b0, 1'b0);
    chk_stall(1'b0, "stall_r0");
    expect_o(ld(r0));
    tick("r0_no_bubble");

    // Hold for three cycles with fresh inputs each cycle.
    drive(x, 1'b0, 1'b0, 1'b0);
    expect_o(ld(x));
    tick("load_x");
    for (int i = 0; i < 3; i++) begin
      drive(mk(15'h3f3f, 1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 3), 100 + i), 1'b0, 1'b1, 1'b0);
      chk_stall(1'b1, "stall_hold");
      expect_o(last_o);
      tick("hold_frozen");
    end

    // Load-use hazard coincident with flush.
    drive(mk(LwCtrl, 1'b1, 5'd1, 5'd7, 5'd0, 20), 1'b0, 1'b0, 1'b0);
    expect_o(ld(mk(LwCtrl, 1'b1, 5'd1, 5'd7, 5'd0, 20)));
    tick("load_lw7");
    drive(mk(AddCtrl, 1'b1, 5'd7, 5'd2, 5'd3, 21), 1'b1, 1'b0, 1'b0);
    chk_stall(hz_en, "stall_hz_flush");
    expect_o(zero_o);
    tick("flush_over_hz");

    // Flush beats hold.
    drive(a, 1'b0, 1'b0, 1'b0);
    expect_o(ld(a));
    tick("load_a2");
    drive(c, 1'b1, 1'b1, 1'b0);
    chk_stall(1'b1, "stall_flush_hold");
    expect_o(zero_o);
    tick("flush_over_hold");

    // Reset during hold, then a normal load.
    drive(a, 1'b0, 1'b0, 1'b0);
    expect_o(ld(a));
    tick("load_a3");
    drive(c, 1'b0, 1'b1, 1'b1);
    cnt_exp = 0;
    expect_o(zero_o);
    tick("reset_mid_hold");
    drive(c, 1'b0, 1'b0, 1'b0);
    expect_o(ld(c));
    tick("post_reset_load");

    // Reset during a load-use stall, then the dependent instruction loads directly.
    drive(lw, 1'b0, 1'b0, 1'b0);
    expect_o(ld(lw));
    tick("load_lw_b");
    drive(add, 1'b0, 1'b0, 1'b1);
    expect_o(zero_o);
    tick("reset_mid_stall");
    drive(add, 1'b0, 1'b0, 1'b0);
    chk_stall(1'b0, "stall_after_reset");
    expect_o(ld(add));
    tick("add_after_reset");

    // jal bundle passes unaltered.
    drive(j, 1'b0, 1'b0, 1'b0);
    expect_o(ld(j));
    tick("jal_pass");

    // Counter saturation: 65537 hazards, then reset.
    if (hz_en) begin
      for (int i = 0; i < 65536; i++) begin
        drive(lw, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        drive(add, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
      end
      cnt_exp += 65536;
      drive(lw, 1'b0, 1'b0, 1'b0);
      expect_o(ld(lw));
      tick("sat_lw");
      drive(add, 1'b0, 1'b0, 1'b0);
      cnt_exp++;
      expect_o(zero_o);
      tick("sat_bubble");
      drive(add, 1'b0, 1'b0, 1'b1);
      cnt_exp = 0;
      expect_o(zero_o);
      tick("sat_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
